// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the streaming multiply-accumulate slice.
//   DEF_A_W / DEF_B_W / DEF_ACC_W / DEF_CNT_W : default widths
//   CNT_SAT   : beat-counter saturation value for the default CNT_W
//   P_MAX_W   : width of the product field carried between stages; the
//               top slices its ACC_W low bits, so ACC_W must stay below it
//   mac_s1_t  : stage-1 payload {product, clr, last}
package mac_pkg;

   localparam int unsigned DEF_A_W   = 4;
   localparam int unsigned DEF_B_W   = 4;
   localparam int unsigned DEF_ACC_W = 16;
   localparam int unsigned DEF_CNT_W = 8;

   localparam int unsigned CNT_SAT = (1 << DEF_CNT_W) - 1;

   // Fixed-width product field so one payload type serves every width
   // configuration; the unused upper bits are constant zero.
   localparam int unsigned P_MAX_W = 32;

   typedef struct packed {
      logic [P_MAX_W-1:0] product;
      logic               clr;
      logic               last;
   } mac_s1_t;

endpackage

// File: rtl/mac_stream_acc_if.sv
// mac_stream_acc_if: operand-in / result-out handshake bundle.
//   in_valid/in_ready, in_a, in_b, in_clr, in_last : operand beat channel
//   out_valid/out_ready, out_acc, out_ovf, out_cnt : group result channel
//   master : operand producer / result consumer
//   slave  : the accumulator engine
interface mac_stream_acc_if import mac_pkg::*; #(
   parameter int unsigned A_W   = DEF_A_W,
   parameter int unsigned B_W   = DEF_B_W,
   parameter int unsigned ACC_W = DEF_ACC_W,
   parameter int unsigned CNT_W = DEF_CNT_W
);

   logic             in_valid;
   logic             in_ready;
   logic [A_W-1:0]   in_a;
   logic [B_W-1:0]   in_b;
   logic             in_clr;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic             out_ovf;
   logic [CNT_W-1:0] out_cnt;

   modport master (
      output in_valid, in_a, in_b, in_clr, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_ovf, out_cnt
   );

   modport slave (
      input  in_valid, in_a, in_b, in_clr, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_ovf, out_cnt
   );

endinterface

// File: rtl/mac_mult_stage.sv
// mac_mult_stage: registered unsigned A_W x B_W multiplier, stage 1.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : pipeline advance (low = frozen)
//   in_valid   : beat accepted this cycle
//   a, b       : operands
//   clr, last  : group flags travelling with the product
//   s1_valid   : stage-1 register holds a beat
//   s1         : product (zero-extended) and flags
module mac_mult_stage import mac_pkg::*; #(
   parameter int unsigned A_W = DEF_A_W,
   parameter int unsigned B_W = DEF_B_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           in_valid,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   input  logic           clr,
   input  logic           last,
   output logic           s1_valid,
   output mac_s1_t        s1
);

   localparam int unsigned PW = A_W + B_W;

   logic [PW-1:0] prod;

   assign prod = PW'(a) * PW'(b);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1.product <= P_MAX_W'(prod);
            s1.clr     <= clr;
            s1.last    <= last;
         end
      end
   end

endmodule

// File: rtl/mac_stream_acc.sv
// mac_stream_acc: pipelined multiply-accumulate over grouped operand beats.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mac_stream_acc_if.slave (operand beats in, group results out)
// Stage 1 (mac_mult_stage) registers a*b; stage 2 accumulates and, on a
// last beat, loads the registered result. Whole pipe stalls while a result
// waits for out_ready. Requires A_W+B_W <= ACC_W < mac_pkg::P_MAX_W.
// Build option MAC_ACC_SATURATE_EN: clamp the group sum at 2^ACC_W-1 on
// carry instead of wrapping.
module mac_stream_acc import mac_pkg::*; #(
   parameter int unsigned A_W   = DEF_A_W,
   parameter int unsigned B_W   = DEF_B_W,
   parameter int unsigned ACC_W = DEF_ACC_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input logic             clk,
   input logic             rst_n,
   mac_stream_acc_if.slave bus
);

   logic             en;
   logic             accept;
   logic             s1_valid;
   mac_s1_t          s1;

   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic [CNT_W-1:0] cnt;
   logic             open;      // a group is in progress (no last seen yet)

   logic [ACC_W-1:0] p;
   logic [ACC_W-1:0] base;
   logic             new_grp;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] acc_nxt;
   logic             ovf_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             fire;
   logic             unused_p_hi;

   logic             out_valid_q;
   logic [ACC_W-1:0] out_acc_q;
   logic             out_ovf_q;
   logic [CNT_W-1:0] out_cnt_q;

   assign en     = !(out_valid_q && !bus.out_ready);
   assign accept = bus.in_valid && en;

   mac_mult_stage #(
      .A_W (A_W),
      .B_W (B_W)
   ) u_mult (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (accept),
      .a        (bus.in_a),
      .b        (bus.in_b),
      .clr      (bus.in_clr),
      .last     (bus.in_last),
      .s1_valid (s1_valid),
      .s1       (s1)
   );

   assign unused_p_hi = |s1.product[P_MAX_W-1:ACC_W];

   always_comb begin
      p       = s1.product[ACC_W-1:0];
      // Reset clears 'open', so the first beat afterwards starts a group.
      new_grp = s1.clr || !open;
      base    = new_grp ? '0 : acc;
      sum     = {1'b0, base} + {1'b0, p};
      ovf_nxt = sum[ACC_W] || (!new_grp && ovf);
`ifdef MAC_ACC_SATURATE_EN
      acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc_nxt = sum[ACC_W-1:0];
`endif
      if (new_grp)
         cnt_nxt = CNT_W'(1);
      else if (&cnt)
         cnt_nxt = cnt;
      else
         cnt_nxt = cnt + 1'b1;
      fire    = s1_valid && s1.last;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc         <= '0;
         ovf         <= 1'b0;
         cnt         <= '0;
         open        <= 1'b0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_cnt_q   <= '0;
      end else if (en) begin
         if (s1_valid) begin
            acc  <= acc_nxt;
            ovf  <= ovf_nxt;
            cnt  <= cnt_nxt;
            open <= !s1.last;
         end
         // en implies any held result is being consumed this edge.
         out_valid_q <= fire;
         if (fire) begin
            out_acc_q <= acc_nxt;
            out_ovf_q <= ovf_nxt;
            out_cnt_q <= cnt_nxt;
         end
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_ovf   = out_ovf_q;
   assign bus.out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_mac_stream_acc.sv
// tb_mac_stream_acc: directed bench for mac_stream_acc.
// Main DUT uses default widths; a second DUT (ACC_W=8, CNT_W=2) sees the
// same stream for overflow, clamp/wrap and count-saturation cases.
module tb_mac_stream_acc;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

`ifdef MAC_ACC_SATURATE_EN
   localparam int unsigned EXP8_2BEAT = 255;
   localparam int unsigned EXP8_4BEAT = 255;
`else
   localparam int unsigned EXP8_2BEAT = 194;
   localparam int unsigned EXP8_4BEAT = 195;
`endif

   mac_stream_acc_if #(.A_W(4), .B_W(4), .ACC_W(16), .CNT_W(8)) bus ();
   mac_stream_acc_if #(.A_W(4), .B_W(4), .ACC_W(8),  .CNT_W(2)) b8 ();

   assign b8.in_valid  = bus.in_valid;
   assign b8.in_a      = bus.in_a;
   assign b8.in_b      = bus.in_b;
   assign b8.in_clr    = bus.in_clr;
   assign b8.in_last   = bus.in_last;
   assign b8.out_ready = bus.out_ready;

   mac_stream_acc #(.A_W(4), .B_W(4), .ACC_W(16), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mac_stream_acc #(.A_W(4), .B_W(4), .ACC_W(8), .CNT_W(2)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat, waits (bounded) for in_ready, returns 1 ns after
   // the accepting edge with in_valid already dropped.
   task automatic beat(input logic [3:0] a, input logic [3:0] b,
                       input logic clr, input logic last);
      int unsigned n;
      n = 0;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_clr   = clr;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         idle();
         n++;
      end
      if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
      idle();
      bus.in_valid = 1'b0;
      bus.in_clr   = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_clr    = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) idle();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_acc",   32'(bus.out_acc),   32'd0);
      chk("rst_out_cnt",   32'(bus.out_cnt),   32'd0);
      chk("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      rst_n = 1'b1;

      // Basic group: 12 + 30 + 14 = 56
      beat(4'd3, 4'd4, 1'b0, 1'b0);
      beat(4'd5, 4'd6, 1'b0, 1'b0);
      beat(4'd2, 4'd7, 1'b0, 1'b1);
      chk("basic_lat1_valid", 32'(bus.out_valid), 32'd0);
      idle();
      chk("basic_valid", 32'(bus.out_valid), 32'd1);
      chk("basic_acc",   32'(bus.out_acc),   32'd56);
      chk("basic_cnt",   32'(bus.out_cnt),   32'd3);
      chk("basic_ovf",   32'(bus.out_ovf),   32'd0);
      idle();
      chk("basic_drop", 32'(bus.out_valid), 32'd0);

      // Single-beat group, then back-to-back group (implicit clear after last)
      beat(4'd15, 4'd15, 1'b1, 1'b1);
      chk("single_lat1_valid", 32'(bus.out_valid), 32'd0);
      beat(4'd1, 4'd2, 1'b0, 1'b1);
      chk("single_valid", 32'(bus.out_valid), 32'd1);
      chk("single_acc",   32'(bus.out_acc),   32'd225);
      chk("single_cnt",   32'(bus.out_cnt),   32'd1);
      idle();
      chk("b2b_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_acc",   32'(bus.out_acc),   32'd2);
      chk("b2b_cnt",   32'(bus.out_cnt),   32'd1);
      idle();
      chk("b2b_drop", 32'(bus.out_valid), 32'd0);

      // Backpressure: result 6 held, (1,1) frozen in stage 1, (3,3,last) waiting
      bus.out_ready = 1'b0;
      beat(4'd2, 4'd3, 1'b0, 1'b1);
      beat(4'd1, 4'd1, 1'b0, 1'b0);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_acc",   32'(bus.out_acc),   32'd6);
      bus.in_a     = 4'd3;
      bus.in_b     = 4'd3;
      bus.in_last  = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle();
         chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
         chk("bp_hold_vld", 32'(bus.out_valid), 32'd1);
         chk("bp_hold_acc", 32'(bus.out_acc),   32'd6);
      end
      bus.out_ready = 1'b1;
      idle();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("bp_release_drop", 32'(bus.out_valid), 32'd0);
      idle();
      chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_next_acc",   32'(bus.out_acc),   32'd10);
      chk("bp_next_cnt",   32'(bus.out_cnt),   32'd2);
      idle();
      chk("bp_next_drop", 32'(bus.out_valid), 32'd0);

      // clr mid-group: partial 4+9 dropped, 1 + 16 = 17
      beat(4'd2, 4'd2, 1'b0, 1'b0);
      beat(4'd3, 4'd3, 1'b0, 1'b0);
      chk("clr_no_out1", 32'(bus.out_valid), 32'd0);
      beat(4'd1, 4'd1, 1'b1, 1'b0);
      chk("clr_no_out2", 32'(bus.out_valid), 32'd0);
      beat(4'd4, 4'd4, 1'b0, 1'b1);
      chk("clr_no_out3", 32'(bus.out_valid), 32'd0);
      idle();
      chk("clr_valid", 32'(bus.out_valid), 32'd1);
      chk("clr_acc",   32'(bus.out_acc),   32'd17);
      chk("clr_cnt",   32'(bus.out_cnt),   32'd2);
      chk("clr_ovf",   32'(bus.out_ovf),   32'd0);
      idle();

      // Overflow: 225 + 225 = 450
      beat(4'd15, 4'd15, 1'b0, 1'b0);
      beat(4'd15, 4'd15, 1'b0, 1'b1);
      idle();
      chk("ovf16_acc",  32'(bus.out_acc), 32'd450);
      chk("ovf16_ovf",  32'(bus.out_ovf), 32'd0);
      chk("ovf8_valid", 32'(b8.out_valid), 32'd1);
      chk("ovf8_acc",   32'(b8.out_acc),   EXP8_2BEAT);
      chk("ovf8_ovf",   32'(b8.out_ovf),   32'd1);
      chk("ovf8_cnt",   32'(b8.out_cnt),   32'd2);
      idle();

      // Four beats: sticky ovf, clamp persistence, CNT_W=2 saturation
      beat(4'd15, 4'd15, 1'b1, 1'b0);
      beat(4'd15, 4'd15, 1'b0, 1'b0);
      beat(4'd1,  4'd1,  1'b0, 1'b0);
      beat(4'd0,  4'd0,  1'b0, 1'b1);
      idle();
      chk("grp4_16_acc", 32'(bus.out_acc), 32'd451);
      chk("grp4_16_cnt", 32'(bus.out_cnt), 32'd4);
      chk("grp4_8_acc",  32'(b8.out_acc),  EXP8_4BEAT);
      chk("grp4_8_ovf",  32'(b8.out_ovf),  32'd1);
      chk("grp4_8_cnt",  32'(b8.out_cnt),  32'd3);
      idle();

      // Reset with (5,5) accumulated and (6,6,last) in stage 1
      beat(4'd5, 4'd5, 1'b0, 1'b0);
      beat(4'd6, 4'd6, 1'b0, 1'b1);
      rst_n = 1'b0;
      idle();
      chk("mrst_valid",    32'(bus.out_valid), 32'd0);
      chk("mrst_acc",      32'(bus.out_acc),   32'd0);
      chk("mrst_cnt",      32'(bus.out_cnt),   32'd0);
      chk("mrst_ovf",      32'(bus.out_ovf),   32'd0);
      chk("mrst_in_ready", 32'(bus.in_ready),  32'd1);
      chk("mrst_acc8",     32'(b8.out_acc),    32'd0);
      rst_n = 1'b1;
      idle();
      chk("mrst_no_spur1", 32'(bus.out_valid), 32'd0);
      idle();
      chk("mrst_no_spur2", 32'(bus.out_valid), 32'd0);
      beat(4'd2, 4'd2, 1'b0, 1'b1);
      idle();
      chk("mrst_next_valid", 32'(bus.out_valid), 32'd1);
      chk("mrst_next_acc",   32'(bus.out_acc),   32'd4);
      chk("mrst_next_cnt",   32'(bus.out_cnt),   32'd1);
      chk("mrst_next_ovf",   32'(bus.out_ovf),   32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_stream_acc.md
Name: mac_stream_acc

Overview:
- Parametrised, pipelined multiply-accumulate engine. Successor to the fixed 4x4 MAC.
- Accepts a stream of operand pairs over a valid/ready handshake and accumulates their products into groups. A group is delimited by a last flag.
- Presents each finished group sum with overflow status and beat count on a registered valid/ready output.
- Sits between the chip's operand input pins/register file and the result readout path.

Parameters:
- A_W, 4, width of unsigned operand a
- B_W, 4, width of unsigned operand b
- ACC_W, 16, accumulator/result width; must be >= A_W+B_W
- CNT_W, 8, beat-counter width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  A_W  operand a, unsigned
- in_b  in  B_W  operand b, unsigned
- in_clr  in  1  beat starts a new group; discards any partial sum
- in_last  in  1  beat closes the current group
- out_valid  out  1  group result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_W  group sum
- out_ovf  out  1  group sum exceeded 2^ACC_W-1 at least once
- out_cnt  out  CNT_W  beats in group, saturating at 2^CNT_W-1

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous, active-low (rst_n).
- While rst_n=0 at an edge, all registers clear: out_valid=0, out_acc=0, out_ovf=0, out_cnt=0, accumulator/count/ovf=0, pipeline valids=0. A group in flight is discarded.
- Accept: a beat is accepted at an edge with in_valid && in_ready.
- Stall: in_ready = !(out_valid && !out_ready). When stalled, the whole pipeline freezes, nothing is lost, and no data is taken.
- Stage 1 (edge E0, accept): product p = in_a*in_b is registered, zero-extended to ACC_W, with clr/last flags.
- Stage 2 (edge E1): the accumulator updates.
  - base = 0 if the beat's clr=1 or the previous beat closed a group (implicit clear after last); otherwise base = the accumulator.
  - sum = base + p, computed at ACC_W+1 bits.
  - The group overflow flag is set if sum[ACC_W]=1, OR'd with the prior flag unless base=0.
  - The count becomes 1 on a new group; otherwise it increments, saturating.
- Result: if the stage-2 beat has last=1, out_acc/out_ovf/out_cnt load at E1 and out_valid=1 from E1.
  - Latency from last-beat accept to out_valid is 2 edges.
- Output hold: out_valid and the output data hold stable until an edge with out_ready=1. out_valid then drops, unless a new last beat completes at that same edge, in which case new data loads and out_valid stays 1.
- Wrap: without the optional feature, sum wraps modulo 2^ACC_W.
- Throughput: 1 beat/cycle while out_ready=1.
- Simultaneous clr+last on one beat: single-beat group, out_acc=a*b, out_cnt=1.
- clr mid-group: the partial sum, ovf and count are dropped; nothing is output for the dropped group.
- A beat with neither flag, after reset: it starts a new group (reset acts as an implicit last).

Optional Feature:
- Macro: MAC_ACC_SATURATE_EN.
- Defined: on carry out, the accumulator clamps to 2^ACC_W-1 and stays clamped for the rest of the group; out_ovf is still set.
- Undefined: modulo wrap as above.
- Stage timing and ports are identical in both cases.

Decomposition:
- Shared package mac_pkg holds:
  - default widths A_W/B_W/ACC_W/CNT_W;
  - a localparam for the counter saturation value;
  - a typedef for the stage-1 payload struct {product, clr, last}.
- One sub-module, mac_mult_stage: a registered A_W x B_W unsigned multiplier with enable (stall) and a valid pipe. The accumulator, counter and output register stay in the top.

Test Plan:
- Basic group: reset; stream (3,4),(5,6),(2,7 last) with out_ready=1 -> out_valid 2 edges after the last accept, out_acc=56, out_cnt=3, out_ovf=0.
- Single beat: (15,15) with clr=1,last=1 -> out_acc=225, out_cnt=1; back-to-back groups at 1 beat/cycle give out_valid high on consecutive cycles.
- Backpressure: hold out_ready=0 after a result -> in_ready=0 and out_acc stable for 5 cycles; release -> next group sums correct and no beat is lost or duplicated.
- Overflow, ACC_W=8: (15,15),(15,15 last) -> out_ovf=1. Macro undefined: out_acc=194. Macro defined: out_acc=255.
- clr mid-group: (2,2),(3,3), then (1,1 clr),(4,4 last) -> out_acc=17, out_cnt=2, no output for the dropped partial group.
- Reset mid-operation: drop rst_n for 1 cycle with 2 beats in the pipe -> all outputs 0, no spurious out_valid; the next group computes from zero.
